// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max-pooling over a raster-order stream.
// A single row of W/2 partial maxima carries the even-row results into the odd row.
module relu_maxpool #(
  parameter int DW = 16,
  parameter int W  = 8,
  parameter int H  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam int RW = (H > 2) ? $clog2(H) : 1;
  localparam int LW = (W > 2) ? $clog2(W / 2) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   linebuf_q [W/2];
  logic [DW-1:0]   linebuf_d [W/2];
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [DW-1:0]   r;
  logic [LW-1:0]   lb_idx;

  function automatic logic [DW-1:0] relu(input logic signed [DW-1:0] x);
    return x[DW-1] ? '0 : $unsigned(x);
  endfunction

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    linebuf_d   = linebuf_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    r           = relu(in_data);
    lb_idx      = LW'(col_q >> 1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          // Window position is fully decided by row/column parity.
          case ({row_q[0], col_q[0]})
            2'b00:   hold_d = r;
            2'b01:   linebuf_d[lb_idx] = umax(hold_q, r);
            2'b10:   hold_d = umax(linebuf_q[lb_idx], r);
            default: begin
              out_data_d  = umax(hold_q, r);
              out_valid_d = 1'b1;
            end
          endcase
          if (col_q == CW'(W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (row_q == RW'(H - 1)) state_d = S_DONE;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Partial maxima are always rewritten on an even row before use, so they need no reset.
  always_ff @(posedge clk) begin
    hold_q    <= hold_d;
    linebuf_q <= linebuf_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool: a 4x4 instance and a 2x2 instance share clock and reset.
module tb_relu_maxpool;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 start_a, in_valid_a, out_valid_a, busy_a, done_a;
  logic signed [DW-1:0] in_data_a;
  logic [DW-1:0]        out_data_a;
  logic                 start_b, in_valid_b, out_valid_b, busy_b, done_b;
  logic signed [DW-1:0] in_data_b;
  logic [DW-1:0]        out_data_b;

  relu_maxpool #(.DW(DW), .W(4), .H(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .busy(busy_a), .done(done_a)
  );

  relu_maxpool #(.DW(DW), .W(2), .H(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  typedef int arr16_t [16];
  typedef int arr4_t  [4];

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents an output.
  exp_t ea, eb;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (out_valid_a) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_unexpected_out: got %0d expected no output", out_data_a);
        end else begin
          ea = qa.pop_front();
          chk("a_data", out_data_a, ea.data);
          chk("a_done", done_a, ea.last);
          chk("a_latency_cycle", cyc, ea.cyc);
        end
      end else if (done_a) begin
        tests++; fails++;
        $display("FAIL a_done_alone: got done=1 expected done only with final output");
      end
      if (out_valid_b) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected_out: got %0d expected no output", out_data_b);
        end else begin
          eb = qb.pop_front();
          chk("b_data", out_data_b, eb.data);
          chk("b_done", done_b, eb.last);
          chk("b_latency_cycle", cyc, eb.cyc);
        end
      end else if (done_b) begin
        tests++; fails++;
        $display("FAIL b_done_alone: got done=1 expected done only with final output");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic v, input logic signed [DW-1:0] d);
    if (sel == 0) begin
      start_a = st; in_valid_a = v; in_data_a = d;
    end else begin
      start_b = st; in_valid_b = v; in_data_b = d;
    end
  endtask

  task automatic send(input int sel, input logic st, input logic signed [DW-1:0] d,
                      input bit has, input logic [DW-1:0] e, input bit last);
    exp_t x;
    drive(sel, st, 1'b1, d);
    tick();
    if (has) begin
      x.data = e;
      x.last = last;
      x.cyc  = cyc;
      if (sel == 0) qa.push_back(x);
      else          qb.push_back(x);
    end
    drive(sel, 1'b0, 1'b0, '0);
  endtask

  task automatic frame4(input arr16_t v, input arr4_t e, input bit gaps, input bit restart);
    int k;
    bit has;
    k = 0;
    drive(0, 1'b1, 1'b0, '0);
    tick();
    drive(0, 1'b0, 1'b0, '0);
    chk("a_busy_after_start", busy_a, 1);
    for (int i = 0; i < 16; i++) begin
      has = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
      if (gaps && ($urandom_range(0, 1) == 1)) tick();
      send(0, restart && (i == 7), v[i], has, e[k], has && (k == 3));
      if (has) k++;
    end
    chk("a_busy_in_done", busy_a, 0);
    tick();
    chk("a_idle_after_done", busy_a, 0);
    chk("a_queue_drained", qa.size(), 0);
  endtask

  task automatic frame2(input int d0, input int d1, input int d2, input int d3, input int e);
    drive(1, 1'b1, 1'b0, '0);
    tick();
    drive(1, 1'b0, 1'b0, '0);
    chk("b_busy_after_start", busy_b, 1);
    send(1, 1'b0, DW'(d0), 1'b0, '0, 1'b0);
    send(1, 1'b0, DW'(d1), 1'b0, '0, 1'b0);
    send(1, 1'b0, DW'(d2), 1'b0, '0, 1'b0);
    send(1, 1'b0, DW'(d3), 1'b1, DW'(e), 1'b1);
    chk("b_busy_in_done", busy_b, 0);
    tick();
    chk("b_queue_drained", qb.size(), 0);
  endtask

  arr16_t asc, neg;
  arr4_t  asc_exp, zero_exp;
  exp_t   x;

  initial begin
    for (int i = 0; i < 16; i++) begin
      asc[i] = i + 1;
      neg[i] = -5;
    end
    asc_exp  = '{6, 8, 14, 16};
    zero_exp = '{0, 0, 0, 0};

    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    tick();
    tick();
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_b_out_data", out_data_b, 0);
    reset = 1'b1;
    tick();

    // Ascending frame, then all-negative frame.
    frame4(asc, asc_exp, 1'b0, 1'b0);
    chk("a_out_data_held", out_data_a, 16);
    frame4(neg, zero_exp, 1'b0, 1'b0);

    // Signed extremes on the 2x2 instance.
    frame2(-32768, 32767, -1, 0, 32767);
    chk("b_out_data_held", out_data_b, 32767);
    frame2(-32768, -32768, -32768, -32768, 0);

    // Gapped input.
    frame4(asc, asc_exp, 1'b1, 1'b0);

    // Reset mid-frame after nine samples.
    drive(0, 1'b1, 1'b0, '0);
    tick();
    drive(0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 9; i++) begin
      send(0, 1'b0, DW'(i + 1), (i == 5) || (i == 7), (i == 5) ? DW'(6) : DW'(8), 1'b0);
    end
    tick();
    chk("mid_rst_partial_drained", qa.size(), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_out_data", out_data_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    tick();
    frame4(asc, asc_exp, 1'b0, 1'b0);

    // in_valid while IDLE must be ignored.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, 1'b1, DW'(100));
      tick();
      chk("idle_in_valid_busy", busy_a, 0);
    end
    drive(0, 1'b0, 1'b0, '0);
    tick();
    // Second start mid-frame must be ignored.
    frame4(asc, asc_exp, 1'b0, 1'b1);

    tick();
    tick();
    chk("final_a_queue_empty", qa.size(), 0);
    chk("final_b_queue_empty", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
